// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU with iterative multiply/divide:
// operation encodings, FSM state type and the iterative-op predicate.
package alu_pkg;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    // Handshake: a request transfers when in_valid && in_ready && !flush;
    // a result transfers when out_valid && out_ready. Both sides are registered.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // True for operations handled by the serial multiply/divide datapath.
    function automatic logic is_iterative(input logic [4:0] op);
        return (op == OP_MUL)  || (op == OP_DIV)  || (op == OP_DIVU) ||
               (op == OP_REM)  || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Serial multiply/divide datapath: one shift-add or restoring-divide step per
// cycle on operand magnitudes, with sign fix-up applied to the final step.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill_i,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            div_by_zero_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    // acc: product accumulator / partial remainder
    // x:   multiplicand (shifts left) / dividend shifting into quotient
    // y:   multiplier (shifts right) / divisor magnitude
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_q, acc_d, x_q, x_d, y_q, y_d;
    logic             is_mul_q, is_mul_d, want_rem_q, want_rem_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic [XLEN-1:0]  acc_n, x_n, y_n;
    logic [XLEN:0]    r_sh;
    logic             a_neg, b_neg, is_signed;

    // One iteration step computed from the current registers.
    always_comb begin
        r_sh  = {acc_q, x_q[XLEN-1]};
        acc_n = acc_q;
        x_n   = x_q;
        y_n   = y_q;
        if (is_mul_q) begin
            acc_n = acc_q + (y_q[0] ? x_q : '0);
            x_n   = {x_q[XLEN-2:0], 1'b0};
            y_n   = {1'b0, y_q[XLEN-1:1]};
        end else if (r_sh >= {1'b0, y_q}) begin
            acc_n = XLEN'(r_sh - {1'b0, y_q});
            x_n   = {x_q[XLEN-2:0], 1'b1};
        end else begin
            acc_n = r_sh[XLEN-1:0];
            x_n   = {x_q[XLEN-2:0], 1'b0};
        end
    end

    // Final result, valid on the cycle whose edge performs the last step.
    always_comb begin
        if (is_mul_q)        result_o = acc_n;
        else if (want_rem_q) result_o = neg_rem_q ? -acc_n : acc_n;
        else if (dz_q)       result_o = '1;
        else                 result_o = neg_quo_q ? -x_n : x_n;
    end

    assign done_o        = (cnt_q == CNT_W'(1));
    assign div_by_zero_o = dz_q;

    // Operand capture on start, stepping while the counter is non-zero.
    always_comb begin
        is_signed  = (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg      = is_signed && a_i[XLEN-1];
        b_neg      = is_signed && b_i[XLEN-1];
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        is_mul_d   = is_mul_q;
        want_rem_d = want_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        if (kill_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d      = CNT_W'(XLEN);
            acc_d      = '0;
            is_mul_d   = (op_i == OP_MUL);
            want_rem_d = (op_i == OP_REM) || (op_i == OP_REMU);
            neg_quo_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            dz_d       = (op_i != OP_MUL) && (b_i == '0);
            x_d        = a_neg ? -a_i : a_i;
            y_d        = b_neg ? -b_i : b_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            acc_d = acc_n;
            x_d   = x_n;
            y_d   = y_n;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            is_mul_q   <= 1'b0;
            want_rem_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            is_mul_q   <= is_mul_d;
            want_rem_q <= want_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative multiply/divide, all delivered through a registered valid/ready
// output so the pipeline can stall on multi-cycle operations.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int CTRL_W  = 5,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ALUSrc,
    input  logic [CTRL_W-1:0] ALU_control,
    input  logic [XLEN-1:0]   read_data_1,
    input  logic [XLEN-1:0]   read_data_2,
    input  logic [XLEN-1:0]   imm_gen_output,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALU_result,
    output logic              zero,
    output logic              div_by_zero,
    output alu_state_e        dbg_state_o
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            dz_q, dz_d;

    logic [4:0]      op_c;
    logic [XLEN-1:0] b_sel, simple_res, iter_res;
    logic [SHAMT_W-1:0] shamt;
    logic            accept, iter_start, iter_done, iter_dz;

    assign op_c       = 5'(ALU_control);
    assign b_sel      = ALUSrc ? imm_gen_output : read_data_2;
    assign shamt      = b_sel[SHAMT_W-1:0];
    assign accept     = in_valid && in_ready && !flush;
    assign iter_start = accept && is_iterative(op_c);

    // Single-cycle operations; unknown codes fall back to ADD.
    always_comb begin
        case (op_c)
            OP_AND:  simple_res = read_data_1 & b_sel;
            OP_OR:   simple_res = read_data_1 | b_sel;
            OP_XOR:  simple_res = read_data_1 ^ b_sel;
            OP_SLL:  simple_res = read_data_1 << shamt;
            OP_SRL:  simple_res = read_data_1 >> shamt;
            OP_SUB:  simple_res = read_data_1 - b_sel;
            OP_SRA:  simple_res = $unsigned($signed(read_data_1) >>> shamt);
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(read_data_1) < $signed(b_sel)};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, read_data_1 < b_sel};
            default: simple_res = read_data_1 + b_sel;
        endcase
    end

    alu_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk           (clk),
        .rst_n         (rst_n),
        .kill_i        (flush),
        .start_i       (iter_start),
        .op_i          (op_c),
        .a_i           (read_data_1),
        .b_i           (b_sel),
        .done_o        (iter_done),
        .result_o      (iter_res),
        .div_by_zero_o (iter_dz)
    );

    // Next state and result capture; flush overrides everything and keeps
    // the previous (discarded) result registers untouched.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        dz_d     = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_iterative(op_c)) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = simple_res;
                        dz_d     = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_d  = ST_DONE;
                    result_d = iter_res;
                    dz_d     = iter_dz;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            dz_d     = dz_q;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign ALU_result  = result_q;
    assign zero        = (result_q == '0);
    assign div_by_zero = dz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=64): directed cases, then random ops
// compared against a plain-arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, ALUSrc, out_valid, out_ready;
    logic [4:0]      ALU_control;
    logic [63:0]     read_data_1, read_data_2, imm_gen_output, ALU_result;
    logic            zero, div_by_zero;
    alu_state_e      dbg_state;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp;
    logic        last_dz;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN), .CTRL_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ALUSrc         (ALUSrc),
        .ALU_control    (ALU_control),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2),
        .imm_gen_output (imm_gen_output),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ALU_result     (ALU_result),
        .zero           (zero),
        .div_by_zero    (div_by_zero),
        .dbg_state_o    (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from the arithmetic rules of each op.
    function automatic void model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic dz);
        longint sa, sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b[5:0]);
        dz = 1'b0;
        case (op)
            5'b00000: r = a & b;
            5'b00001: r = a | b;
            5'b00011: r = a ^ b;
            5'b00100: r = a << sh;
            5'b00101: r = a >> sh;
            5'b00110: r = a - b;
            5'b00111: r = sa >>> sh;
            5'b01000: r = (sa < sb) ? 64'd1 : 64'd0;
            5'b01001: r = (a < b) ? 64'd1 : 64'd0;
            5'b10000: r = a * b;
            5'b10100: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else if (a == MIN64 && sb == -1) r = a;
                else r = sa / sb;
            end
            5'b10101: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else r = a / b;
            end
            5'b10110: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else if (a == MIN64 && sb == -1) r = 0;
                else r = sa % sb;
            end
            5'b10111: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else r = a % b;
            end
            default: r = a + b;
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, wait for the result and
    // check it; the result is left held in DONE (out_ready low).
    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] rd2, input logic [63:0] imm, input logic src);
        logic [63:0] b, r;
        logic dz;
        int lat, exp_lat;
        b = src ? imm : rd2;
        model(op, a, b, r, dz);
        exp_q.push_back(r);
        exp_lat = (op inside {5'b10000, 5'b10100, 5'b10101, 5'b10110, 5'b10111}) ? XLEN + 1 : 1;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1; ALU_control = op; ALUSrc = src;
        read_data_1 = a; read_data_2 = rd2; imm_gen_output = imm;
        @(posedge clk); #1;
        in_valid = 0;
        ALU_control = 5'($urandom); ALUSrc = 1'($urandom);
        read_data_1 = {$urandom, $urandom}; read_data_2 = {$urandom, $urandom};
        imm_gen_output = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        last_exp = exp_q.pop_front();
        last_dz  = dz;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, ALU_result, last_exp);
        chk({tag, "_zero"}, zero, (last_exp == 0));
        chk({tag, "_dz"}, div_by_zero, dz);
        chk({tag, "_busy_ready"}, in_ready, 0);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, "_rel_valid"}, out_valid, 0);
        chk({tag, "_rel_ready"}, in_ready, 1);
    endtask

    logic [4:0] op_tab [0:17];

    initial begin
        int rises;
        logic [63:0] a, b;
        logic [4:0] op;
        logic src;
        op_tab = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                   5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b10000, 5'b10100,
                   5'b10101, 5'b10110, 5'b10111, 5'b01010, 5'b10001, 5'b11111};
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; ALUSrc = 0;
        ALU_control = '0; read_data_1 = '0; read_data_2 = '0; imm_gen_output = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", ALU_result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst_n = 1;

        // Directed cases.
        run_op("add", 5'b00010, 64'd5, -64'd3, 64'd0, 0);         release_out("add");
        run_op("sub0", 5'b00110, 64'd7, 64'd7, 64'd99, 0);        release_out("sub0");
        run_op("and_imm", 5'b00000, 64'hFF, 64'hDEAD, 64'h10, 1); release_out("and_imm");
        run_op("unk", 5'b11111, 64'd1, 64'd2, 64'd0, 0);          release_out("unk");
        run_op("div", 5'b10100, -64'd7, 64'd2, 64'd0, 0);         release_out("div");
        run_op("rem", 5'b10110, -64'd7, 64'd2, 64'd0, 0);         release_out("rem");
        run_op("mul", 5'b10000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 0); release_out("mul");
        run_op("rem_ovf", 5'b10110, MIN64, '1, 64'd0, 0);          release_out("rem_ovf");
        run_op("div_ovf", 5'b10100, MIN64, '1, 64'd0, 0);          release_out("div_ovf");
        run_op("sra", 5'b00111, MIN64, 64'd0, 64'd67, 1);          release_out("sra");
        run_op("slt", 5'b01000, -64'd1, 64'd1, 64'd0, 0);          release_out("slt");
        run_op("sltu", 5'b01001, -64'd1, 64'd1, 64'd0, 0);         release_out("sltu");

        // Backpressure: result and handshake held while out_ready stays low.
        run_op("bp", 5'b00011, 64'h1234, 64'h00FF, 64'd0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_result", ALU_result, last_exp);
            chk("bp_ready", in_ready, 0);
        end
        release_out("bp");
        run_op("bp_next", 5'b00001, 64'hF0, 64'h0F, 64'd0, 0);     release_out("bp_next");

        // Flush mid-divide with a simultaneous request.
        @(negedge clk);
        in_valid = 1; ALU_control = 5'b10100; ALUSrc = 0;
        read_data_1 = 64'd1000; read_data_2 = 64'd7;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1; in_valid = 1; ALU_control = 5'b00010;
        @(posedge clk); #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        flush = 0; in_valid = 0;
        rises = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        chk("flush_no_result", 64'(rises), 0);

        // Reset mid-multiply after a divide-by-zero left div_by_zero set.
        run_op("divu0", 5'b10101, 64'd9, 64'd0, 64'd0, 0);         release_out("divu0");
        @(negedge clk);
        in_valid = 1; ALU_control = 5'b10000; read_data_1 = 64'd3; read_data_2 = 64'd5;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_dz", div_by_zero, last_dz);
        rst_n = 0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", ALU_result, 0);
        chk("arst_zero", zero, 1);
        chk("arst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1;
        rises = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        chk("arst_no_result", 64'(rises), 0);

        // Random ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            op = op_tab[$urandom_range(0, 17)];
            case ($urandom_range(0, 3))
                0: a = MIN64;
                1: a = 64'($urandom_range(0, 100));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 4))
                0: b = 64'd0;
                1: b = '1;
                2: b = 64'($urandom_range(1, 70));
                default: b = {$urandom, $urandom};
            endcase
            src = 1'($urandom);
            if (src) run_op("rnd", op, a, {$urandom, $urandom}, b, 1);
            else     run_op("rnd", op, a, b, {$urandom, $urandom}, 0);
            release_out("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
